parity_mult_core: RTL and testbench

PARITY_MULT_CORE -- requirements
Module: parity_mult_core

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_shift_add_dp.sv | 57 +++++
 rtl/parity_mult_core.sv | 114 +++++++++++
 tb/tb_parity_mult_core.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the parity-checked shift-add multiplier.
package mult_pkg;

  localparam int ARG_W = 16;
  localparam int RES_W = 32;
  localparam int STEPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ERR  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Parity is the XOR-reduction of the argument bits.
  function automatic logic parity_ok(input logic [ARG_W-1:0] v, input logic p);
    return (^v) == p;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Magnitude/accumulator datapath: one multiplier bit is consumed per step.
module mult_shift_add_dp
  import mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    load,
  input  logic                    step,
  input  logic signed [ARG_W-1:0] a,
  input  logic signed [ARG_W-1:0] b,
  output logic        [RES_W-1:0] prod_nxt,
  output logic                    neg
);

  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [ARG_W-1:0] mplier_q, mplier_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [RES_W-1:0] partial;

  // Two's-complement magnitude kept unsigned, so -32768 maps to 32768.
  function automatic logic [ARG_W-1:0] mag(input logic signed [ARG_W-1:0] v);
    return v[ARG_W-1] ? (~v + 16'd1) : v;
  endfunction

  always_comb begin
    partial  = mplier_q[0] ? mcand_q : '0;
    prod_nxt = acc_q + partial;
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    if (load) begin
      mcand_d  = {16'd0, mag(a)};
      mplier_d = mag(b);
      acc_d    = '0;
      neg_d    = a[ARG_W-1] ^ b[ARG_W-1];
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = prod_nxt;
    end
  end

  // Pure datapath: every register is loaded before it is consumed.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    neg_q    <= neg_d;
  end

  assign neg = neg_q;

endmodule

// File: rtl/parity_mult_core.sv
// Parity-checked 16x16 signed multiplier: request/ack capture, 16-step
// shift-add calculation, registered result with parity and error flag.
module parity_mult_core
  import mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic signed [ARG_W-1:0] arg_a,
  input  logic                    arg_a_parity,
  input  logic signed [ARG_W-1:0] arg_b,
  input  logic                    arg_b_parity,
  output logic                    ack,
  output logic signed [RES_W-1:0] result,
  output logic                    result_parity,
  output logic                    result_rdy,
  output logic                    arg_parity_error
);

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic             ack_q, ack_d;
  logic             rdy_q, rdy_d;
  logic             perr_q, perr_d;
  logic             rpar_q, rpar_d;
  logic [RES_W-1:0] result_q, result_d;

  logic             dp_load, dp_step, dp_neg;
  logic [RES_W-1:0] dp_prod_nxt, signed_prod;
  logic             args_ok;

  mult_shift_add_dp u_dp (
    .clk      (clk),
    .load     (dp_load),
    .step     (dp_step),
    .a        (arg_a),
    .b        (arg_b),
    .prod_nxt (dp_prod_nxt),
    .neg      (dp_neg)
  );

  assign args_ok     = parity_ok(arg_a, arg_a_parity) && parity_ok(arg_b, arg_b_parity);
  assign signed_prod = dp_neg ? (~dp_prod_nxt + 32'd1) : dp_prod_nxt;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ack_d    = 1'b0;
    rdy_d    = 1'b0;
    perr_d   = perr_q;
    rpar_d   = rpar_q;
    result_d = result_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          ack_d   = 1'b1;
          dp_load = 1'b1;
          step_d  = 4'd0;
          state_d = args_ok ? CALC : ERR;
        end
      end
      CALC: begin
        dp_step = 1'b1;
        step_d  = step_q + 4'd1;
        // The final step folds its partial product straight into the result.
        if (step_q == 4'(STEPS - 1)) begin
          result_d = signed_prod;
          rpar_d   = ^signed_prod;
          perr_d   = 1'b0;
          rdy_d    = 1'b1;
          state_d  = DONE;
        end
      end
      ERR: begin
        result_d = '0;
        rpar_d   = 1'b0;
        perr_d   = 1'b1;
        rdy_d    = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= 4'd0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      perr_q   <= 1'b0;
      rpar_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      ack_q    <= ack_d;
      rdy_q    <= rdy_d;
      perr_q   <= perr_d;
      rpar_q   <= rpar_d;
      result_q <= result_d;
    end
  end

  assign ack              = ack_q;
  assign result_rdy       = rdy_q;
  assign result           = result_q;
  assign result_parity    = rpar_q;
  assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_parity_mult_core.sv
// Scoreboard bench for parity_mult_core: directed vectors, monitor-side checking.
module tb_parity_mult_core;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req;
  logic signed [15:0] arg_a, arg_b;
  logic               arg_a_parity, arg_b_parity;
  logic               ack, result_rdy, result_parity, arg_parity_error;
  logic signed [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        rpar;
    logic        perr;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  int   ack_cnt = 0;
  int   rdy_cnt = 0;

  parity_mult_core dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ack) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
      if (result_rdy) begin
        rdy_cnt++;
        chk("ack_rdy_overlap", {31'd0, ack}, 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_rdy", {31'd0, result_rdy}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("result_parity", {31'd0, result_parity}, {31'd0, e.rpar});
          chk("arg_parity_error", {31'd0, arg_parity_error}, {31'd0, e.perr});
          chk("latency", 32'(cyc - ack_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_rdy(input int n);
    int c0;
    int k;
    c0 = rdy_cnt;
    k = 0;
    while (rdy_cnt == c0 && k < n) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (rdy_cnt == c0) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic signed [15:0] a, input logic signed [15:0] b,
                     input logic bad_a, input logic bad_b, input exp_t e);
    @(negedge clk);
    req = 1'b1;
    arg_a = a;
    arg_b = b;
    arg_a_parity = (^a) ^ bad_a;
    arg_b_parity = (^b) ^ bad_b;
    q.push_back(e);
    @(posedge clk);
    #1 req = 1'b0;
    wait_rdy(30);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, result_rdy}, 32'd0);
    chk({tag, "_perr"}, {31'd0, arg_parity_error}, 32'd0);
    chk({tag, "_rpar"}, {31'd0, result_parity}, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
  endtask

  initial begin
    int a0;
    rst_n = 1'b0;
    req = 1'b0;
    arg_a = '0;
    arg_b = '0;
    arg_a_parity = 1'b0;
    arg_b_parity = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    run(16'sd3, 16'sd4, 1'b0, 1'b0, '{32'd12, 1'b0, 1'b0, 16});
    run(-16'sd32768, -16'sd32768, 1'b0, 1'b0, '{32'h40000000, 1'b1, 1'b0, 16});
    run(-16'sd5, 16'sd7, 1'b0, 1'b0, '{32'hFFFFFFDD, 1'b0, 1'b0, 16});
    run(16'sd1, 16'sd2, 1'b1, 1'b0, '{32'd0, 1'b0, 1'b1, 1});
    run(16'sd32767, -16'sd1, 1'b0, 1'b0, '{32'hFFFF8001, 1'b0, 1'b0, 16});
    run(16'sd2, 16'sd3, 1'b0, 1'b1, '{32'd0, 1'b0, 1'b1, 1});
    run(-16'sd1, -16'sd1, 1'b0, 1'b0, '{32'd1, 1'b1, 1'b0, 16});
    run(16'sd0, 16'sd5, 1'b0, 1'b0, '{32'd0, 1'b0, 1'b0, 16});

    // Outputs hold after result_rdy drops.
    repeat (5) @(negedge clk);
    chk("hold_result", result, 32'd0);
    chk("hold_perr", {31'd0, arg_parity_error}, 32'd0);

    // Reset in the middle of a calculation discards it.
    @(negedge clk);
    req = 1'b1;
    arg_a = 16'sd100;
    arg_b = 16'sd100;
    arg_a_parity = ^arg_a;
    arg_b_parity = ^arg_b;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1 chk_zero_outputs("postreset");
    run(16'sd2, 16'sd3, 1'b0, 1'b0, '{32'd6, 1'b0, 1'b0, 16});

    // Request and argument churn during CALC is ignored.
    a0 = ack_cnt;
    @(negedge clk);
    req = 1'b1;
    arg_a = 16'sd300;
    arg_b = -16'sd7;
    arg_a_parity = ^arg_a;
    arg_b_parity = ^arg_b;
    q.push_back('{32'hFFFFF7CC, 1'b1, 1'b0, 16});
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = i[0];
      arg_a = 16'($urandom);
      arg_b = 16'($urandom);
      arg_a_parity = $urandom_range(0, 1) == 1;
      arg_b_parity = $urandom_range(0, 1) == 1;
    end
    req = 1'b0;
    wait_rdy(30);
    chk("single_ack", 32'(ack_cnt - a0), 32'd1);
    repeat (2) @(negedge clk);

    // req held high: back-to-back transactions.
    @(negedge clk);
    req = 1'b1;
    arg_a = 16'sd7;
    arg_b = -16'sd9;
    arg_a_parity = ^arg_a;
    arg_b_parity = ^arg_b;
    q.push_back('{32'hFFFFFFC1, 1'b1, 1'b0, 16});
    wait_rdy(30);
    arg_a = -16'sd2;
    arg_b = -16'sd3;
    arg_a_parity = ^arg_a;
    arg_b_parity = ^arg_b;
    q.push_back('{32'd6, 1'b0, 1'b0, 16});
    wait_rdy(30);
    req = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_b2b", result, 32'd6);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
